sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Initiator side of the magnitude-compare interface: a successive-approximation engine that finds an unknown WIDTH-bit target by issuing "target > probe" queries to an external comparator responder.
- Works in unsigned or two's-complement signed mode.
- Sits beside the comparator block: drives its probe operand and consumes its greater-than flag, one query per clock, MSB first.
- Result is ready WIDTH+1 cycles after start.

Parameters:
- WIDTH, 4, bit width of target, probe and result (>=2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a search; sampled only in IDLE
- signed_mode  in  1  1 = two's-complement search, 0 = unsigned; captured on accepted start
- probe  out  WIDTH  operand sent to responder (responder evaluates target > probe)
- probe_valid  out  1  high during each query cycle
- gt_in  in  1  responder answer, combinational in the same cycle as probe; sampled on the edge ending a query cycle
- result  out  WIDTH  found target value, registered, held until next completion
- done  out  1  one-cycle pulse when result updates
- busy  out  1  high in QUERY and DONE

Behaviour:
- Asynchronous reset (active-high) forces:
  - state = IDLE
  - probe = 0, probe_valid = 0, result = 0, done = 0, busy = 0
  - internal candidate c = 0, bit index i = WIDTH-1, mode = 0
- States:
  - IDLE: start=1 at edge E0 → QUERY; c=0, i=WIDTH-1, mode captured from signed_mode.
  - QUERY: trial t = c | (1<<i); offset-domain probe p = t-1 (never underflows, t>=1).
    - probe = p in unsigned mode; p with MSB inverted in signed mode (order-preserving unsigned→signed map).
    - probe_valid = 1.
    - On each edge: if gt_in then c = t; if i==0 → DONE, else i = i-1.
  - DONE: for exactly one cycle, done = 1 and result = c (MSB inverted in signed mode) is visible; next edge → IDLE.
- Timing: start sampled at E0; query cycles span E0–E1 … E(WIDTH-1)–E(WIDTH); done high in the cycle after E(WIDTH); busy low again after E(WIDTH+1).
- probe and probe_valid are registered outputs; probe = 0 whenever probe_valid = 0.
- Boundary and ordering rules:
  - start while busy is ignored, including in the DONE cycle.
  - A new start is accepted in the first IDLE cycle after DONE.
  - signed_mode changes mid-search have no effect.
  - gt_in is don't-care when probe_valid = 0.
  - Result is exact for every target in range: 0..2^WIDTH-1 unsigned, -2^(WIDTH-1)..2^(WIDTH-1)-1 signed.
  - Reset asserted mid-search aborts immediately: no done pulse, result cleared to 0.
- Arithmetic is WIDTH bits wide with no carry out; t-1 is computed only when t>0.

Optional Feature:
- Macro: SAR_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge while in QUERY → IDLE next cycle.
  - probe_valid drops, no done pulse, result keeps its previous value.
  - abort is ignored in IDLE and DONE.
- Undefined: port absent; a search always runs to completion.

Test Plan:
- Unsigned, WIDTH=4, target 9, responder = target>probe → probes 7,11,9,8; gt 1,0,0,1; done one cycle after 4th query; result=9; busy high 5 cycles.
- Signed, target -3 (4'hD) → probes 4'hF,4'hB,4'hD,4'hC; gt 0,1,0,1; result=4'hD.
- Extremes:
  - Unsigned target 0 → probes 7,3,1,0, result 0.
  - Unsigned target 15 → probes 7,11,13,14, result 15.
  - Signed -8 → result 4'h8.
  - Signed +7 → result 4'h7.
- Start pulsed during QUERY and during DONE → ignored, exactly one done.
- Back-to-back start in the first IDLE cycle → second search begins, no lost cycle.
- Reset asserted after 2nd query → outputs 0 immediately, no done.
- With SAR_ABORT_EN, abort in 3rd query → IDLE, prior result (9) retained, no done.

Source files
------------

// File: rtl/sar_search.sv
// sar_search -- successive-approximation search initiator.
//
// Finds an unknown WIDTH-bit target by asking an external comparator
// responder "target > probe" once per clock, MSB first. The search runs in
// an offset (unsigned) domain. In signed mode each probe and the final
// result have their MSB inverted. That map preserves order, so one binary
// search serves both modes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        request a search (sampled only in IDLE)
//   signed_mode  1 = two's-complement, 0 = unsigned (captured on start)
//   abort        (only with SAR_ABORT_EN) abandon a search in progress
//   probe        operand presented to the responder (registered)
//   probe_valid  high during each query cycle (registered)
//   gt_in        responder answer for the current probe
//   result       found target, held until the next completion
//   done         one-cycle pulse when result updates
//   busy         high while querying and in the done cycle
//
// Configuration macro: SAR_ABORT_EN adds the abort input.

module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
`ifdef SAR_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             gt_in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [IW-1:0]    i_q, i_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             probe_valid_q, probe_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] trial_cur;
  logic [WIDTH-1:0] trial_nxt;
  logic [WIDTH-1:0] p_nxt;

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    i_d       = i_q;
    mode_d    = mode_q;
    result_d  = result_q;
    trial_cur = c_q | (ONE << i_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_QUERY;
          c_d     = '0;
          i_d     = IW'(WIDTH - 1);
          mode_d  = signed_mode;
        end
      end
      S_QUERY: begin
        if (gt_in) begin
          c_d = trial_cur;
        end
        if (i_q == '0) begin
          state_d  = S_DONE;
          result_d = mode_q ? (c_d ^ MSB) : c_d;
        end else begin
          i_d = i_q - IW'(1);
        end
`ifdef SAR_ABORT_EN
        if (abort) begin
          state_d  = S_IDLE;
          c_d      = c_q;
          i_d      = i_q;
          result_d = result_q;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The outputs are registered. The probe for the coming query cycle is
    // built from the next candidate and bit index, so it is ready on the
    // same edge that enters or continues the query. The trial always has
    // one bit set, so trial-1 cannot wrap.
    trial_nxt     = c_d | (ONE << i_d);
    p_nxt         = trial_nxt - ONE;
    probe_valid_d = (state_d == S_QUERY);
    probe_d       = '0;
    if (state_d == S_QUERY) begin
      probe_d = mode_d ? (p_nxt ^ MSB) : p_nxt;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      c_q           <= '0;
      i_q           <= IW'(WIDTH - 1);
      mode_q        <= 1'b0;
      probe_q       <= '0;
      probe_valid_q <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      i_q           <= i_d;
      mode_q        <= mode_d;
      probe_q       <= probe_d;
      probe_valid_q <= probe_valid_d;
      result_q      <= result_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign probe       = probe_q;
  assign probe_valid = probe_valid_q;
  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  localparam int W = 4;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         gt_in;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
`ifdef SAR_ABORT_EN
  logic         abort;
`endif

  logic [W-1:0] target;
  logic         tmode;

  int total = 0;
  int bad   = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
`ifdef SAR_ABORT_EN
    .abort       (abort),
`endif
    .probe       (probe),
    .probe_valid (probe_valid),
    .gt_in       (gt_in),
    .result      (result),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Comparator responder.
  always_comb begin
    if (tmode) gt_in = $signed(target) > $signed(probe);
    else       gt_in = target > probe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k-th probe of a binary search over [0, 2^W) in the offset domain:
  // the top k bits of the offset target are already known, so the probe
  // is the midpoint of the remaining block, minus one.
  function automatic logic [W-1:0] exp_probe(input logic [W-1:0] tgt, input bit sm, input int k);
    int unsigned u, blk, p;
    logic [W-1:0] pw;
    u   = sm ? int'(tgt ^ MSB) : int'(tgt);
    blk = 1 << (W - k);
    p   = (u / blk) * blk + blk / 2 - 1;
    pw  = W'(p);
    return sm ? (pw ^ MSB) : pw;
  endfunction

  function automatic bit exp_gt(input logic [W-1:0] tgt, input bit sm, input int k);
    int unsigned u, blk, p;
    u   = sm ? int'(tgt ^ MSB) : int'(tgt);
    blk = 1 << (W - k);
    p   = (u / blk) * blk + blk / 2 - 1;
    return u > p;
  endfunction

  // Called at a negedge in IDLE. Returns at the negedge of the first IDLE
  // cycle after DONE, so a following call starts back-to-back.
  task automatic run_search(input logic [W-1:0] tgt, input bit sm);
    target      = tgt;
    tmode       = sm;
    signed_mode = sm;
    start       = 1'b1;
    @(negedge clk);
    for (int k = 0; k < W; k++) begin
      signed_mode = 1'($urandom);
      start       = (k == 1) ? 1'b1 : 1'($urandom);
      check("probe_valid", 32'(probe_valid), 32'd1);
      check("probe", 32'(probe), 32'(exp_probe(tgt, sm, k)));
      check("gt", 32'(gt_in), 32'(exp_gt(tgt, sm, k)));
      check("busy_q", 32'(busy), 32'd1);
      check("done_q", 32'(done), 32'd0);
      @(negedge clk);
    end
    start = 1'b1;
    check("done", 32'(done), 32'd1);
    check("result", 32'(result), 32'(tgt));
    check("busy_d", 32'(busy), 32'd1);
    check("pv_d", 32'(probe_valid), 32'd0);
    check("probe_d", 32'(probe), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("done_i", 32'(done), 32'd0);
    check("busy_i", 32'(busy), 32'd0);
    check("pv_i", 32'(probe_valid), 32'd0);
    check("result_hold", 32'(result), 32'(tgt));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    target      = '0;
    tmode       = 1'b0;
`ifdef SAR_ABORT_EN
    abort       = 1'b0;
`endif
    #1;
    check("rst_probe", 32'(probe), 32'd0);
    check("rst_pv", 32'(probe_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_search(4'd9, 1'b0);
    run_search(4'hD, 1'b1);
    run_search(4'd0, 1'b0);
    run_search(4'd15, 1'b0);
    run_search(4'h8, 1'b1);
    run_search(4'h7, 1'b1);

    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
      end
      run_search(W'($urandom), 1'($urandom));
    end

    // Reset in the middle of a search: outputs clear at once, no done.
    run_search(4'd9, 1'b0);
    target = 4'd5; tmode = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_probe", 32'(probe), 32'd0);
    check("mid_rst_pv", 32'(probe_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

`ifdef SAR_ABORT_EN
    run_search(4'd9, 1'b0);
    target = 4'd3; tmode = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ab_pv3", 32'(probe_valid), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_pv", 32'(probe_valid), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_result", 32'(result), 32'd9);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("ab_nodone", 32'(done), 32'd0);
    end
    run_search(4'd3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
